booth_mul_arbiter: RTL and testbench
====================================

// Module: booth_mul_arbiter
// PURPOSE
//  Shares one sequential Booth multiplier (top_BOOTH: start/done, 7x7 signed -> 14b) between NREQ
//  systolic-array requesters. Round-robin arbitration, operand capture, one start pulse per job,
//  completion detection, result routing back to the owning requester, and a watchdog timeout.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  DW       7   operand width; result width is 2*DW
//  TIMEOUT  64  max WAIT cycles before a job is aborted with error
// PORTS
//  clk         in   1         system clock, rising edge
//  rst         in   1         asynchronous reset, active-high
//  req         in   NREQ      per-requester request; held high until matching gnt bit seen
//  a_in        in   NREQ*DW   operand A, requester i at [i*DW +: DW]
//  b_in        in   NREQ*DW   operand B, same packing
//  gnt         out  NREQ      one-hot, one-cycle: operands of requester i captured
//  rsp_valid   out  NREQ      one-hot, one-cycle: result for requester i on rsp_data
//  rsp_data    out  2*DW      product (two's complement); 0 when rsp_err
//  rsp_err     out  1         qualifies rsp_valid: job timed out
//  busy        out  1         high in every state except IDLE
//  mul_start   out  1         start pulse to multiplier
//  mul_a       out  DW        latched operand A to multiplier
//  mul_b       out  DW        latched operand B to multiplier
//  mul_done    in   1         multiplier done (level)
//  mul_result  in   2*DW      multiplier product
// BEHAVIOUR
//  - All outputs registered. Reset (async, immediate): state=IDLE, gnt/rsp_valid/rsp_err/busy/
//    mul_start=0, mul_a/mul_b/rsp_data=0, owner=0, last=NREQ-1 (req 0 wins first), wd=0, low_seen=0.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if |req, winner = first set bit scanning last+1, last+2, ... modulo NREQ (wrap-around).
//    At that edge: owner<=winner, mul_a/mul_b<=winner operands, go ISSUE. No req: stay.
//  - ISSUE (exactly 1 cycle): gnt[owner]=1, mul_start=1, busy=1. Next: WAIT, wd=0, low_seen=0.
//  - WAIT: mul_start=0, mul_a/mul_b held stable. low_seen<=1 once mul_done sampled 0.
//    Completion = mul_done==1 && low_seen==1 (stale done from previous job ignored).
//    On completion: rsp_data<=mul_result, rsp_err<=0, go RESP.
//    Else wd increments; wd==TIMEOUT-1 without completion: rsp_data<=0, rsp_err<=1, go RESP.
//    Completion and timeout on same edge: completion wins.
//  - RESP (exactly 1 cycle): rsp_valid[owner]=1; last<=owner; go IDLE. rsp_data held until next RESP.
//  - Requests arriving in ISSUE/WAIT/RESP are queued by the requester holding req; only
//    evaluated in IDLE. A requester may reassert req in its own RESP cycle; it then ranks
//    lowest in the next IDLE arbitration.
//  - gnt latency: req high at IDLE edge k -> gnt high cycle k+1. Min job = 4 cycles + multiplier.
//  - req dropped before gnt is a protocol violation; no recovery required.
//  - rst mid-job: in-flight result discarded, no rsp_valid issued; low_seen=0 guards against
//    the aborted multiplier's done being taken as a new completion.
// TESTING
//  1 req[0], a=0x76, b=0x0d -> gnt[0] 1 cycle with mul_start, rsp_valid[0], rsp_data=0x3F7E, err=0.
//  2 req=4'b1111 after reset, all held -> gnt order 0,1,2,3, then 0; each rsp routed to its owner.
//  3 req[0] reasserted every RESP, req[2] held -> service alternates 0,2,0,2 (no starvation).
//  4 model never raises mul_done, TIMEOUT=16 -> rsp_valid[owner], err=1, data=0, 16 WAIT cycles.
//  5 rst pulse mid-WAIT -> all outputs 0 at once; then req[1] a=0x09 b=0x0a -> rsp_data=0x005A.
//  6 mul_done held high from prior job through ISSUE -> ignored until low then high; correct data.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential start/done Booth multiplier between NREQ requesters,
// with operand capture, result routing back to the owner and a watchdog on the multiplier.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 7,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DW-1:0]     a_in,
  input  logic [NREQ*DW-1:0]     b_in,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic signed [2*DW-1:0] rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   mul_start,
  output logic signed [DW-1:0]   mul_a,
  output logic signed [DW-1:0]   mul_b,
  input  logic                   mul_done,
  input  logic signed [2*DW-1:0] mul_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;
  logic [IW-1:0] winner;
  logic [WW-1:0] wd;
  logic          low_seen;
  logic          any_req;

  // First requester after the previously served one, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] l);
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;
    int            idx;
    pick  = l;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(l) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IW'(idx);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] sel);
    return NREQ'(1) << sel;
  endfunction

  assign any_req = |req;
  assign winner  = rr_pick(req, last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_data  <= '0;
      owner     <= '0;
      last      <= IW'(NREQ - 1);
      wd        <= '0;
      low_seen  <= 1'b0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            mul_a     <= a_in[winner*DW +: DW];
            mul_b     <= b_in[winner*DW +: DW];
            gnt       <= onehot(winner);
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wd       <= '0;
          low_seen <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          // A done level left over from an earlier job only counts after it has been seen low.
          if (!mul_done) low_seen <= 1'b1;
          if (mul_done && low_seen) begin
            rsp_data  <= mul_result;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(owner);
            state     <= RESP;
          end else if (wd == WD_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= onehot(owner);
            state     <= RESP;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        RESP: begin
          last  <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: behavioural start/done multiplier, requester engine and a
// scoreboard of expected grants/responses in service order.
`timescale 1ns/1ps
module tb_booth_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 7;
  localparam int TIMEOUT = 16;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*DW-1:0]     a_in;
  logic [NREQ*DW-1:0]     b_in;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [2*DW-1:0]        rsp_data;
  logic                   rsp_err;
  logic                   busy;
  logic                   mul_start;
  logic [DW-1:0]          mul_a;
  logic [DW-1:0]          mul_b;
  logic                   mul_done;
  logic [2*DW-1:0]        mul_result;

  booth_mul_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result)
  );

  typedef struct {
    int              id;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] data;
    logic            err;
    int              lat;
  } exp_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  typedef struct {
    int              id;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] data;
  } vec_t;

  exp_t expq[$];
  op_t  opq[NREQ][$];
  bit   hold[NREQ];
  bit   wait_rsp[NREQ];
  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  bit granted = 0;

  int lat_cfg = 3;
  int stale_n = 0;
  bit never_done = 0;

  int                     m_cnt = 0;
  int                     m_hold = 0;
  logic signed [DW-1:0]   m_pa;
  logic signed [DW-1:0]   m_pb;
  logic signed [2*DW-1:0] m_prod;
  op_t                    e_tmp;
  exp_t                   mon_x;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},       32'(gnt),       32'(0));
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_rsp_err"},   32'(rsp_err),   32'(0));
    check({tag, "_busy"},      32'(busy),      32'(0));
    check({tag, "_mul_start"}, 32'(mul_start), 32'(0));
    check({tag, "_mul_a"},     32'(mul_a),     32'(0));
    check({tag, "_mul_b"},     32'(mul_b),     32'(0));
    check({tag, "_rsp_data"},  32'(rsp_data),  32'(0));
  endtask

  task automatic push_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    opq[id].push_back(o);
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [2*DW-1:0] d, input logic e, input int lat);
    exp_t x;
    x.id = id; x.a = a; x.b = b; x.data = d; x.err = e; x.lat = lat;
    expq.push_back(x);
  endtask

  task automatic flush_all();
    expq.delete();
    for (int i = 0; i < NREQ; i++) opq[i].delete();
    granted = 0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d jobs still pending after %0d cycles, expected 0", expq.size(), budget);
      flush_all();
    end
    repeat (2) @(posedge clk);
  endtask

  // Multiplier model: done level drops after start (optionally late), rises lat_cfg cycles later.
  initial begin
    mul_done   = 1'b0;
    mul_result = '0;
    m_pa = '0;
    m_pb = '0;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        m_pa   = mul_a;
        m_pb   = mul_b;
        m_hold = stale_n;
        m_cnt  = never_done ? 0 : lat_cfg;
        if (m_hold == 0) mul_done = 1'b0;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) mul_done = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_prod     = m_pa * m_pb;
          mul_result = m_prod;
          mul_done   = 1'b1;
        end
      end
    end
  end

  // Requester engine: hold mode keeps req up across jobs; otherwise req drops at gnt and is
  // raised again in the requester's own response cycle.
  initial begin
    req  = '0;
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      hold[i]     = 1'b0;
      wait_rsp[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rst) begin
          req[i]      = 1'b0;
          wait_rsp[i] = 1'b0;
        end else if (gnt[i] && req[i]) begin
          if (opq[i].size() > 0) e_tmp = opq[i].pop_front();
          if (opq[i].size() > 0) begin
            a_in[i*DW +: DW] = opq[i][0].a;
            b_in[i*DW +: DW] = opq[i][0].b;
            if (!hold[i]) begin
              req[i]      = 1'b0;
              wait_rsp[i] = 1'b1;
            end
          end else begin
            req[i] = 1'b0;
          end
        end else if (!req[i] && opq[i].size() > 0 && (!wait_rsp[i] || rsp_valid[i])) begin
          a_in[i*DW +: DW] = opq[i][0].a;
          b_in[i*DW +: DW] = opq[i][0].b;
          req[i]      = 1'b1;
          wait_rsp[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (gnt != 0) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_gnt: got 0x%0h, expected no grant", gnt);
        end else begin
          check("gnt_owner",    32'(gnt),       32'(1) << expq[0].id);
          check("gnt_repeat",   32'(granted),   32'(0));
          check("gnt_mul_start", 32'(mul_start), 32'(1));
          check("gnt_busy",     32'(busy),      32'(1));
          check("gnt_mul_a",    32'(mul_a),     32'(expq[0].a));
          check("gnt_mul_b",    32'(mul_b),     32'(expq[0].b));
          granted = 1'b1;
          gnt_cyc = cyc;
        end
      end
      if (rsp_valid != 0) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid 0x%0h, expected none", rsp_valid);
        end else begin
          mon_x = expq.pop_front();
          check("rsp_owner", 32'(rsp_valid), 32'(1) << mon_x.id);
          check("rsp_data",  32'(rsp_data),  32'(mon_x.data));
          check("rsp_err",   32'(rsp_err),   32'(mon_x.err));
          check("rsp_busy",  32'(busy),      32'(1));
          if (mon_x.lat > 0) check("rsp_latency", 32'(cyc - gnt_cyc), 32'(mon_x.lat));
          granted = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    vecs[0] = '{id: 0, a: 7'h76, b: 7'h0d, data: 14'h3F7E};
    vecs[1] = '{id: 1, a: 7'h40, b: 7'h40, data: 14'h1000};
    vecs[2] = '{id: 2, a: 7'h40, b: 7'h3F, data: 14'h3040};
    vecs[3] = '{id: 3, a: 7'h3F, b: 7'h3F, data: 14'h0F81};
    vecs[4] = '{id: 0, a: 7'h7F, b: 7'h7F, data: 14'h0001};
    vecs[5] = '{id: 1, a: 7'h00, b: 7'h55, data: 14'h0000};
    vecs[6] = '{id: 2, a: 7'h7F, b: 7'h01, data: 14'h3FFF};
    vecs[7] = '{id: 3, a: 7'h05, b: 7'h7D, data: 14'h3FF1};

    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("idle");

    // Single jobs, one requester at a time: ISSUE + 3 WAIT cycles -> rsp 4 cycles after gnt.
    for (int k = 0; k < 8; k++) begin
      push_op(vecs[k].id, vecs[k].a, vecs[k].b);
      push_exp(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].data, 1'b0, 4);
      wait_drain(200);
    end

    // All four requesting together after id3 was served last: order 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) hold[i] = 1'b1;
    push_op(0, 7'h03, 7'h04);
    push_op(0, 7'h06, 7'h07);
    push_op(1, 7'h7E, 7'h05);
    push_op(2, 7'h10, 7'h10);
    push_op(3, 7'h3F, 7'h7F);
    push_exp(0, 7'h03, 7'h04, 14'h000C, 1'b0, 4);
    push_exp(1, 7'h7E, 7'h05, 14'h3FF6, 1'b0, 4);
    push_exp(2, 7'h10, 7'h10, 14'h0100, 1'b0, 4);
    push_exp(3, 7'h3F, 7'h7F, 14'h3FC1, 1'b0, 4);
    push_exp(0, 7'h06, 7'h07, 14'h002A, 1'b0, 4);
    wait_drain(400);

    // req0 re-raised in its own RESP, req2 held: 2,0,2,0,2,0 (id0 was served last).
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    hold[3] = 1'b0;
    push_op(0, 7'h01, 7'h01);
    push_op(0, 7'h02, 7'h02);
    push_op(0, 7'h03, 7'h03);
    push_op(2, 7'h7C, 7'h02);
    push_op(2, 7'h05, 7'h05);
    push_op(2, 7'h7B, 7'h7B);
    push_exp(2, 7'h7C, 7'h02, 14'h3FF8, 1'b0, 4);
    push_exp(0, 7'h01, 7'h01, 14'h0001, 1'b0, 4);
    push_exp(2, 7'h05, 7'h05, 14'h0019, 1'b0, 4);
    push_exp(0, 7'h02, 7'h02, 14'h0004, 1'b0, 4);
    push_exp(2, 7'h7B, 7'h7B, 14'h0019, 1'b0, 4);
    push_exp(0, 7'h03, 7'h03, 14'h0009, 1'b0, 4);
    wait_drain(400);
    hold[2] = 1'b0;

    // Multiplier never completes: 16 WAIT cycles then an error response with zero data.
    never_done = 1'b1;
    push_op(3, 7'h05, 7'h06);
    push_exp(3, 7'h05, 7'h06, 14'h0000, 1'b1, 17);
    wait_drain(200);
    never_done = 1'b0;

    // Done arrives on the very edge the watchdog expires: the result wins.
    lat_cfg = 16;
    push_op(1, 7'h07, 7'h7D);
    push_exp(1, 7'h07, 7'h7D, 14'h3FEB, 1'b0, 17);
    wait_drain(200);
    lat_cfg = 3;

    // Reset in the middle of WAIT: outputs clear at once and the job is dropped.
    push_op(2, 7'h11, 7'h22);
    push_exp(2, 7'h11, 7'h22, 14'h0000, 1'b0, 0);
    n = 0;
    while (gnt == 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_gnt_before_reset", 32'(n < 50), 32'(1));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("midreset");
    flush_all();
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    push_op(1, 7'h09, 7'h0a);
    push_exp(1, 7'h09, 7'h0a, 14'h005A, 1'b0, 4);
    wait_drain(200);

    // Done still high from the previous job for 3 WAIT cycles: must not be taken as completion.
    check("stale_done_precondition", 32'(mul_done), 32'(1));
    stale_n = 3;
    push_op(0, 7'h7D, 7'h7A);
    push_exp(0, 7'h7D, 7'h7A, 14'h0012, 1'b0, 7);
    wait_drain(200);
    stale_n = 0;

    repeat (5) @(posedge clk);
    #1;
    check("final_busy", 32'(busy), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
